// File: rtl/credit_bid_scheduler.sv
// rtl/credit_bid_scheduler.sv - four-way credit bid scheduler with refill and starvation aging
// Optional macro STARVE_PROMOTE_EN: aged eligible bidders outrank bid value in DECIDE.
module credit_bid_scheduler #(
  parameter int COLLECT_CYCLES = 4,
  parameter int HOLD_CYCLES    = 8,
  parameter int REFILL_PERIOD  = 64,
  parameter int REFILL_AMT     = 8,
  parameter int INIT_CREDIT    = 512,
  parameter int STARVE_LIMIT   = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  req_i,
  input  logic [3:0]  bid_0_i,
  input  logic [3:0]  bid_1_i,
  input  logic [3:0]  bid_2_i,
  input  logic [3:0]  bid_3_i,
  input  logic        release_i,
  output logic [3:0]  grant_o,
  output logic        busy_o,
  output logic [39:0] balance_flat_o
);

  localparam int CCW = (COLLECT_CYCLES > 1) ? $clog2(COLLECT_CYCLES) : 1;
  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int RCW = $clog2(REFILL_PERIOD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DECIDE,
    S_GRANT
  } state_t;

  state_t          state_q, state_d;
  logic [CCW-1:0]  coll_cnt_q, coll_cnt_d;
  logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [3:0]      grant_q, grant_d;
  logic [3:0]      pend_q, pend_d;
  logic [1:0]      rr_q, rr_d;
  logic [RCW-1:0]  ref_cnt_q, ref_cnt_d;
  logic [3:0]      bid_q [4];
  logic [3:0]      bid_d [4];
  logic [9:0]      bal_q [4];
  logic [9:0]      bal_d [4];
  logic [5:0]      age_q [4];
  logic [5:0]      age_d [4];

  logic [3:0]      bid_in [4];
  logic [3:0]      elig;
  logic            found;
  logic [1:0]      win_idx;
  logic            refill_wrap;

  assign bid_in[0] = bid_0_i;
  assign bid_in[1] = bid_1_i;
  assign bid_in[2] = bid_2_i;
  assign bid_in[3] = bid_3_i;

  assign grant_o = grant_q;
  assign busy_o  = (state_q != S_IDLE);

  // Pack the four balances onto the flat output bus
  always_comb begin
    balance_flat_o = '0;
    for (int i = 0; i < 4; i++) begin
      balance_flat_o[10*i +: 10] = bal_q[i];
    end
  end

  // Pick the winner: scan from rr_q so the first tied bidder in rotation order keeps the lead
  always_comb begin
    logic [1:0] idx;
    logic       better;
`ifdef STARVE_PROMOTE_EN
    logic [3:0] prom;
`endif
    idx     = '0;
    better  = 1'b0;
    found   = 1'b0;
    win_idx = '0;
    for (int i = 0; i < 4; i++) begin
      elig[i] = pend_q[i] && (bal_q[i] >= {6'd0, bid_q[i]});
    end
`ifdef STARVE_PROMOTE_EN
    for (int i = 0; i < 4; i++) begin
      prom[i] = elig[i] && (age_q[i] >= 6'(STARVE_LIMIT));
    end
`endif
    for (int k = 0; k < 4; k++) begin
      idx = rr_q + k[1:0];
`ifdef STARVE_PROMOTE_EN
      if (prom[idx] != prom[win_idx]) begin
        better = prom[idx];
      end else if (prom[idx]) begin
        better = age_q[idx] > age_q[win_idx];
      end else begin
        better = bid_q[idx] > bid_q[win_idx];
      end
`else
      better = bid_q[idx] > bid_q[win_idx];
`endif
      if (elig[idx] && (!found || better)) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
  end

  // Round sequencing: next state, window/tenure counters and the registered grant
  always_comb begin
    state_d    = state_q;
    coll_cnt_d = coll_cnt_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (|req_i) begin
          state_d    = S_COLLECT;
          coll_cnt_d = '0;
        end
      end
      S_COLLECT: begin
        if (coll_cnt_q == CCW'(COLLECT_CYCLES - 1)) begin
          state_d = S_DECIDE;
        end else begin
          coll_cnt_d = coll_cnt_q + CCW'(1);
        end
      end
      S_DECIDE: begin
        if (found) begin
          state_d    = S_GRANT;
          grant_d    = 4'b0001 << win_idx;
          hold_cnt_d = '0;
        end else begin
          state_d = S_IDLE;
          grant_d = '0;
        end
      end
      S_GRANT: begin
        if (release_i || (hold_cnt_q == HCW'(HOLD_CYCLES - 1))) begin
          state_d = S_IDLE;
          grant_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HCW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Bookkeeping: bid capture, pend flags, aging, rotation pointer, debit and refill
  always_comb begin
    logic        collect_en;
    logic        decide;
    logic [10:0] sum;
    logic [10:0] debit;
    collect_en  = (state_q == S_IDLE) || (state_q == S_COLLECT);
    decide      = (state_q == S_DECIDE);
    sum         = '0;
    debit       = '0;
    pend_d      = pend_q;
    rr_d        = rr_q;
    refill_wrap = (ref_cnt_q == RCW'(REFILL_PERIOD - 1));
    ref_cnt_d   = refill_wrap ? '0 : ref_cnt_q + RCW'(1);
    if (decide && found) begin
      rr_d = win_idx + 2'd1;
    end
    for (int i = 0; i < 4; i++) begin
      bid_d[i] = bid_q[i];
      age_d[i] = age_q[i];
      if (collect_en && req_i[i]) begin
        pend_d[i] = 1'b1;
        bid_d[i]  = bid_in[i];
      end
      if (decide) begin
        pend_d[i] = 1'b0;
        if (found && (win_idx == i[1:0])) begin
          age_d[i] = '0;
        end else if (pend_q[i]) begin
          age_d[i] = (age_q[i] == 6'd63) ? 6'd63 : age_q[i] + 6'd1;
        end else if (found) begin
          age_d[i] = '0;
        end
      end
      debit = (decide && found && (win_idx == i[1:0])) ? {7'd0, bid_q[i]} : 11'd0;
      sum   = {1'b0, bal_q[i]} - debit + (refill_wrap ? 11'(REFILL_AMT) : 11'd0);
      bal_d[i] = (sum > 11'd1023) ? 10'd1023 : sum[9:0];
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      coll_cnt_q <= '0;
      hold_cnt_q <= '0;
      grant_q    <= '0;
      pend_q     <= '0;
      rr_q       <= '0;
      ref_cnt_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        bid_q[i] <= '0;
        bal_q[i] <= 10'(INIT_CREDIT);
        age_q[i] <= '0;
      end
    end else begin
      coll_cnt_q <= coll_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      pend_q     <= pend_d;
      rr_q       <= rr_d;
      ref_cnt_q  <= ref_cnt_d;
      for (int i = 0; i < 4; i++) begin
        bid_q[i] <= bid_d[i];
        bal_q[i] <= bal_d[i];
        age_q[i] <= age_d[i];
      end
    end
  end

endmodule

// File: tb/tb_credit_bid_scheduler.sv
// tb/tb_credit_bid_scheduler.sv - directed self-checking bench for credit_bid_scheduler
module tb_credit_bid_scheduler;

  localparam int HOLD = 8;
  localparam int RPER = 64;
  localparam int RAMT = 8;
  localparam int INIT = 512;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [3:0]  req_i;
  logic [3:0]  bid_0_i, bid_1_i, bid_2_i, bid_3_i;
  logic        release_i;
  logic [3:0]  grant_o;
  logic        busy_o;
  logic [39:0] balance_flat_o;

  int ncmp = 0;
  int nfail = 0;
  int exp_bal [4];
  int rcnt = 0;
  int nref = 0;
  int dbg_w = -1;
  int dbg_amt = 0;

  always #5 clk = ~clk;

  credit_bid_scheduler #(
    .COLLECT_CYCLES(4),
    .HOLD_CYCLES(HOLD),
    .REFILL_PERIOD(RPER),
    .REFILL_AMT(RAMT),
    .INIT_CREDIT(INIT),
    .STARVE_LIMIT(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .req_i(req_i),
    .bid_0_i(bid_0_i),
    .bid_1_i(bid_1_i),
    .bid_2_i(bid_2_i),
    .bid_3_i(bid_3_i),
    .release_i(release_i),
    .grant_o(grant_o),
    .busy_o(busy_o),
    .balance_flat_o(balance_flat_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] exp_flat();
    logic [39:0] f;
    for (int i = 0; i < 4; i++) f[10*i +: 10] = 10'(exp_bal[i]);
    return f;
  endfunction

  // One clock edge plus the balance model: reset, refill wrap and the announced debit
  task automatic tick();
    logic r;
    int   v;
    logic wrap;
    r = rst_i;
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 4; i++) exp_bal[i] = INIT;
      rcnt = 0;
      nref = 0;
    end else begin
      wrap = (rcnt == RPER - 1);
      rcnt = wrap ? 0 : rcnt + 1;
      if (wrap) nref++;
      for (int i = 0; i < 4; i++) begin
        v = exp_bal[i];
        if (dbg_w == i) v = v - dbg_amt;
        if (wrap) v = v + RAMT;
        if (v > 1023) v = 1023;
        exp_bal[i] = v;
      end
    end
    dbg_w = -1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  // A full round started from IDLE; exp_w < 0 means no grant expected
  task automatic round(input logic [3:0] rq, input logic [3:0] b0, input logic [3:0] b1,
                       input logic [3:0] b2, input logic [3:0] b3, input int exp_w,
                       input int rel_at, input int rst_at, input string tag);
    logic [3:0] exp_g;
    int         bid_w;
    exp_g = (exp_w >= 0) ? (4'b0001 << exp_w) : 4'b0000;
    case (exp_w)
      0: bid_w = b0;
      1: bid_w = b1;
      2: bid_w = b2;
      3: bid_w = b3;
      default: bid_w = 0;
    endcase
    req_i = rq; bid_0_i = b0; bid_1_i = b1; bid_2_i = b2; bid_3_i = b3;
    tick();
    check({tag, " busy_collect"}, busy_o, 1);
    for (int c = 2; c <= 5; c++) begin
      tick();
      check({tag, " grant_early"}, grant_o, 0);
    end
    req_i = 4'b0000;
    if (exp_w >= 0) begin
      dbg_w = exp_w;
      dbg_amt = bid_w;
    end
    tick();
    check({tag, " grant_rise"}, grant_o, exp_g);
    check({tag, " balances"}, balance_flat_o, exp_flat());
    if (exp_w < 0) begin
      check({tag, " busy_nowin"}, busy_o, 0);
      return;
    end
    for (int k = 1; k <= HOLD; k++) begin
      check({tag, " grant_hold"}, grant_o, exp_g);
      if (rel_at == k) begin
        release_i = 1'b1;
        tick();
        release_i = 1'b0;
        check({tag, " grant_release"}, grant_o, 0);
        check({tag, " busy_release"}, busy_o, 0);
        return;
      end
      if (rst_at == k) begin
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check({tag, " grant_rst"}, grant_o, 0);
        check({tag, " busy_rst"}, busy_o, 0);
        check({tag, " bal_rst"}, balance_flat_o, {4{10'd512}});
        return;
      end
      tick();
    end
    check({tag, " grant_end"}, grant_o, 0);
    check({tag, " busy_end"}, busy_o, 0);
  endtask

  initial begin
    int guard;
    int b;
    for (int i = 0; i < 4; i++) exp_bal[i] = INIT;
    rst_i = 1'b1; req_i = '0; release_i = 1'b0;
    bid_0_i = '0; bid_1_i = '0; bid_2_i = '0; bid_3_i = '0;
    tick();
    tick();
    rst_i = 1'b0;
    check("reset grant", grant_o, 0);
    check("reset busy", busy_o, 0);
    check("reset balances", balance_flat_o, {4{10'd512}});

    round(4'b0001, 4'd5, 4'd0, 4'd0, 4'd0, 0, 0, 0, "single");
    check("single bal0", balance_flat_o[9:0], 507);

    do_reset();
    round(4'b0111, 4'd3, 4'd9, 4'd9, 4'd0, 1, 0, 0, "tie1");
    check("tie1 bal1", balance_flat_o[19:10], 503);
    round(4'b0111, 4'd3, 4'd9, 4'd9, 4'd0, 2, 1, 0, "tie2");
    check("tie2 bal2", balance_flat_o[29:20], 503);
    round(4'b0001, 4'd1, 4'd0, 4'd0, 4'd0, 0, 3, 0, "release3");
    round(4'b0010, 4'd0, 4'd2, 4'd0, 4'd0, 1, 0, 2, "rst_grant");

    round(4'b0011, 4'd1, 4'd15, 4'd0, 4'd0, 1, 1, 0, "promo1");
    round(4'b0011, 4'd1, 4'd15, 4'd0, 4'd0, 1, 1, 0, "promo2");
`ifdef STARVE_PROMOTE_EN
    round(4'b0011, 4'd1, 4'd15, 4'd0, 4'd0, 0, 1, 0, "promo3");
`else
    round(4'b0011, 4'd1, 4'd15, 4'd0, 4'd0, 1, 1, 0, "promo3");
`endif

    do_reset();
    guard = 0;
    while (exp_bal[3] >= 40 && guard < 100) begin
      round(4'b1000, 4'd0, 4'd0, 4'd0, 4'd15, 3, 1, 0, "drain");
      guard++;
    end
    guard = 0;
    while (rcnt != 0 && guard < 200) begin tick(); guard++; end
    guard = 0;
    while (exp_bal[3] > 2 && guard < 10) begin
      b = (exp_bal[3] - 2 > 15) ? 15 : exp_bal[3] - 2;
      round(4'b1000, 4'd0, 4'd0, 4'd0, 4'(b), 3, 1, 0, "drain2");
      guard++;
    end
    check("drained bal3", balance_flat_o[39:30], 2);
    round(4'b1000, 4'd0, 4'd0, 4'd0, 4'd7, -1, 0, 0, "poor");
    check("poor age3", dut.age_q[3], 1);
    guard = 0;
    while (rcnt != 0 && guard < 200) begin tick(); guard++; end
    check("refill bal3", balance_flat_o[39:30], 10);
    round(4'b1000, 4'd0, 4'd0, 4'd0, 4'd7, 3, 1, 0, "rich");
    check("rich bal3", balance_flat_o[39:30], 3);

    do_reset();
    round(4'b0001, 4'd4, 4'd0, 4'd0, 4'd0, 0, 1, 0, "sat0");
    round(4'b0010, 4'd0, 4'd4, 4'd0, 4'd0, 1, 1, 0, "sat1");
    guard = 0;
    while (!(nref == 64 && rcnt == 58) && guard < 6000) begin tick(); guard++; end
    check("wait budget", guard < 6000, 1);
    check("pre bal0", balance_flat_o[9:0], 1020);
    check("pre bal1", balance_flat_o[19:10], 1020);
    round(4'b0010, 4'd0, 4'd9, 4'd0, 4'd0, 1, 1, 0, "coincide");
    check("coincide bal1", balance_flat_o[19:10], 1019);
    check("sat bal0", balance_flat_o[9:0], 1023);
    check("sat bal2", balance_flat_o[29:20], 1023);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
